// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWrite,
    StResp
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extract with sign/zero extension, and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] ld_word,
  input  logic [31:0] st_base,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [4:0]  bit_off;

  assign bit_off = {addr_lo, 3'b000};

  always_comb begin
    ld_byte = ld_word[bit_off +: 8];
    ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    case (size)
      SZ_BYTE: ld_data = {{24{ld_byte[7] & ~is_unsigned}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_half[15] & ~is_unsigned}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

  always_comb begin
    st_word = st_base;
    case (size)
      SZ_BYTE: st_word[bit_off +: 8] = st_data[7:0];
      SZ_HALF: begin
        if (addr_lo[1]) st_word[31:16] = st_data[15:0];
        else            st_word[15:0]  = st_data[15:0];
      end
      default: st_word = st_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store initiator on a word-wide memory port; sub-word stores use RMW.
// Define LSU_ALIGN_CHECK_EN to report misaligned half/word accesses as errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t        state_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;

  logic [ADDR_W-1:0] addr_eff;
  logic              req_err;
  logic [31:0]       ld_data;
  logic [31:0]       st_word;

  always_comb begin
    addr_eff = req_addr;
    req_err  = (req_size == 2'b11);
`ifdef LSU_ALIGN_CHECK_EN
    if (req_size == SZ_HALF && req_addr[0])          req_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
`else
    if (req_size == SZ_HALF) addr_eff[0]   = 1'b0;
    if (req_size == SZ_WORD) addr_eff[1:0] = 2'b00;
`endif
  end

  lsu_lane_align u_lane_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .addr_lo     (addr_q[1:0]),
    .ld_word     (mem_rdata),
    .st_base     (rdata_q),
    .st_data     (wdata_q),
    .ld_data     (ld_data),
    .st_word     (st_word)
  );

  // Response fields default to 0 every cycle so they are only non-zero while in RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= addr_eff;
            wdata_q <= req_wdata;
            if (req_err) begin
              resp_err_q <= 1'b1;
              state_q    <= StResp;
            end else begin
              state_q <= StAccess;
            end
          end
        end
        StAccess: begin
          rdata_q <= mem_rdata;
          if (!we_q) begin
            resp_rdata_q <= ld_data;
            state_q      <= StResp;
          end else if (size_q == SZ_WORD) begin
            state_q <= StResp;
          end else begin
            state_q <= StWrite;
          end
        end
        StWrite: state_q <= StResp;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready  = rst_n & (state_q == StIdle);
  assign resp_valid = rst_n & (state_q == StResp);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Gated by rst_n so a reset asserted mid-store never reaches memory.
  assign mem_we    = rst_n & (((state_q == StAccess) & we_q & (size_q == SZ_WORD)) |
                              (state_q == StWrite));
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = (state_q == StWrite) ? st_word : wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  logic        pk_en = 1'b0;
  logic [3:0]  pk_idx = '0;
  logic [31:0] pk_val = '0;
  int          cyc = 0;
  int          we_cnt = 0;

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      mem[mem_addr[5:2]] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end else if (pk_en) begin
      mem[pk_idx] <= pk_val;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_rdata"}, resp_rdata, e.rdata);
        chk({e.name, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
        chk({e.name, "_lat"}, cyc - e.acc + 1, e.lat);
      end
    end
  end

  task automatic poke(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    pk_en = 1'b1; pk_idx = idx; pk_val = val;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic xact(input string name, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                      input int exp_we);
    exp_t e;
    int   we0;
    int   t;
    we0 = we_cnt;
    issue(we, size, uns, addr, wdata);
    e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat; e.acc = cyc; e.name = name;
    sb.push_back(e);
    t = 0;
    while (sb.size() != 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no response expected one within 10 cycles", name);
      sb.delete();
    end
    chk({name, "_we_cycles"}, we_cnt - we0, exp_we);
  endtask

  int we_before;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    poke(4'd4, 32'h8899AABB);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready_after", {31'b0, req_ready}, 32'd1);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);

    // Loads from 0x8899AABB at 0x10
    xact("lb_11",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0);
    xact("lbu_11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2, 0);
    xact("lb_12",  1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'hFFFFFF99, 1'b0, 2, 0);
    xact("lh_12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 0);
    xact("lhu_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00008899, 1'b0, 2, 0);
    xact("lh_10",  1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 2, 0);
    xact("lw_10",  1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 0);

    xact("sb_13",  1'b1, 2'b00, 1'b0, 32'h13, 32'h5C, 32'h0, 1'b0, 3, 1);
    chk("sb_13_word", mem[4], 32'h5C99AABB);

    poke(4'd4, 32'h8899AABB);
    xact("sh_10",  1'b1, 2'b01, 1'b0, 32'h10, 32'h1234, 32'h0, 1'b0, 3, 1);
    chk("sh_10_word", mem[4], 32'h88991234);
    xact("sw_20",  1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
    chk("sw_20_word", mem[8], 32'hDEADBEEF);
    xact("lw_20",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
    xact("lbu_20", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'h000000EF, 1'b0, 2, 0);

`ifdef LSU_ALIGN_CHECK_EN
    xact("lw_22",  1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1, 1, 0);
    xact("sh_11",  1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF, 32'h0, 1'b1, 1, 0);
`else
    xact("lw_22",  1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
    xact("lhu_23", 1'b0, 2'b01, 1'b1, 32'h23, 32'h0, 32'h0000DEAD, 1'b0, 2, 0);
`endif

    // Reset asserted while the sub-word store is in its write cycle
    poke(4'd4, 32'h8899AABB);
    we_before = we_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h5C);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_we_before", {31'b0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we_gated", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mid_word", mem[4], 32'h8899AABB);
    chk("rst_mid_we_cycles", we_cnt - we_before, 32'd0);

    xact("rsv_size", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
    xact("rsv_size_st", 1'b1, 2'b11, 1'b0, 32'h10, 32'h55, 32'h0, 1'b1, 1, 0);
    chk("rsv_size_word", mem[4], 32'h8899AABB);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
